alu_exec_unit: RTL and testbench

//  Execute-stage ALU consuming the 3-bit ALUctr code generated by aluctr. Accepts
//  one operation per valid/ready handshake, registers the result, and presents it

---
 rtl/alu_exec_unit_if.sv | 30 +++
 rtl/alu_exec_unit.sv | 187 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operation/result handshake bundle for alu_exec_unit.
//   Request side : in_valid, in_ready, ALUctr, a, b
//   Response side: out_valid, out_ready, result, zero, overflow, illegal
// The master modport is for the upstream/downstream logic that drives requests
// and consumes results. The slave modport is for the ALU itself.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUctr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, ALUctr, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, ALUctr, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides. The result and
// flags are registered and held until the consumer takes them.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_exec_unit_if.slave (request: in_valid/in_ready/ALUctr/a/b,
//             response: out_valid/out_ready/result/zero/overflow/illegal)
// Codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, others illegal.
// Optional macro ALU_MUL_EN: code 011 becomes an unsigned shift-add multiply
// (low WIDTH bits of the product), one bit per cycle, WIDTH cycles in BUSY.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  alu_exec_unit_if.slave   bus
);

`ifdef ALU_MUL_EN
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StDone, StBusy} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_mul;
`endif

  logic             in_ready;
  logic             accept;
  logic             sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic             less;
  logic [WIDTH-1:0] res_op;
  logic             ovf_op;
  logic             ill_op;

  // Shared adder: SUB and SLT both compute a + ~b + 1.
  always_comb begin
    sub     = (bus.ALUctr == 3'b110) || (bus.ALUctr == 3'b111);
    b_op    = sub ? ~bus.b : bus.b;
    sum     = bus.a + b_op + {{(WIDTH-1){1'b0}}, sub};
    add_ovf = (bus.a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    // Sign of the difference is wrong exactly when the subtraction overflowed.
    less    = sum[WIDTH-1] ^ add_ovf;
  end

  // Single-cycle result for the presented code.
  always_comb begin
    res_op = '0;
    ovf_op = 1'b0;
    ill_op = 1'b0;
`ifdef ALU_MUL_EN
    is_mul = 1'b0;
`endif
    case (bus.ALUctr)
      3'b000: res_op = bus.a & bus.b;
      3'b001: res_op = bus.a | bus.b;
      3'b010: begin
        res_op = sum;
        ovf_op = add_ovf;
      end
      3'b110: begin
        res_op = sum;
        ovf_op = add_ovf;
      end
      3'b111: res_op = {{(WIDTH-1){1'b0}}, less};
`ifdef ALU_MUL_EN
      3'b011: is_mul = 1'b1;
`endif
      default: ill_op = 1'b1;
    endcase
  end

  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (is_mul) begin
            state_d  = StBusy;
            acc_d    = '0;
            mcand_d  = bus.a;
            mplier_d = bus.b;
            cnt_d    = '0;
          end else
`endif
          begin
            state_d  = StDone;
            result_d = res_op;
            zero_d   = (res_op == '0);
            ovf_d    = ovf_op;
            ill_d    = ill_op;
          end
        end else if ((state_q == StDone) && bus.out_ready) begin
          state_d = StIdle;
        end
      end
`ifdef ALU_MUL_EN
      StBusy: begin
        // Add the multiplicand when the current multiplier LSB is set; the
        // multiplicand walks left so bits above WIDTH fall off naturally.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          result_d = acc_d;
          zero_d   = (acc_d == '0);
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed operations with literal expectations plus a
// reference model/scoreboard that checks every presented result and its latency.
module tb_alu_exec_unit;
  localparam int unsigned W = 32;
  localparam logic [2:0] OpAnd = 3'b000, OpOr = 3'b001, OpAdd = 3'b010, OpSub = 3'b110,
                         OpSlt = 3'b111, OpMul = 3'b011;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         v;
    logic         il;
    int           acc;
    int           lat;
    bit           seen;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Architectural meaning of each code, using wide signed/unsigned arithmetic.
  function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, s;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0; e.v = 1'b0; e.il = 1'b0; e.lat = 1; e.seen = 1'b0; e.acc = 0;
    case (c)
      OpAnd: e.res = x & y;
      OpOr:  e.res = x | y;
      OpAdd, OpSub: begin
        s = (c == OpAdd) ? sx + sy : sx - sy;
        e.res = s[W-1:0];
        e.v   = (s != longint'($signed(s[W-1:0])));
      end
      OpSlt: e.res = (sx < sy) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      OpMul: begin
        p = 64'(x) * 64'(y);
        e.res = p[W-1:0];
        e.lat = W + 1;
      end
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Scoreboard compare, sampled on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (!reset_n) begin
      q.delete();
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          if (!q[0].seen) begin
            chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            q[0].seen = 1'b1;
          end
          chk("model_result", bus.result, q[0].res);
          chk("model_flags", {29'd0, bus.zero, bus.overflow, bus.illegal},
              {29'd0, q[0].z, q[0].v, q[0].il});
          if (bus.out_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0) begin
        // Operation in flight but nothing presented: the unit must not accept.
        chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
        if ((cyc - q[0].acc) > q[0].lat) begin
          chk("missing_valid", 32'd0, 32'd1);
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.ALUctr, bus.a, bus.b);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  // Present one op; returns at 1ns after the accepting edge with in_valid low.
  task automatic op(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                    output int waits);
    bus.ALUctr   = c;
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    waits        = 0;
    @(negedge clock);
    while (!bus.in_ready && waits < 60) begin
      waits++;
      @(negedge clock);
    end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.ALUctr   = 3'b101;
    bus.a        = 32'hdead_beef;
    bus.b        = 32'h1357_9bdf;
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] r, input logic z,
                         input logic v, input logic il);
    chk({name, "_result"}, bus.result, r);
    chk({name, "_flags"}, {29'd0, bus.zero, bus.overflow, bus.illegal}, {29'd0, z, v, il});
  endtask

  task automatic wait_mul(input logic [W-1:0] r);
    int n;
    n = 1;
    @(negedge clock);
    while (!bus.out_valid && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("mul_latency", 32'(n), 32'(W + 1));
    chk_out("mul", r, (r == '0), 1'b0, 1'b0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int w;
    reset_n       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ALUctr    = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    #1 reset_n = 1'b0;
    #10;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_out("rst", 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;

    // Add overflow, then back-to-back SUB to zero.
    op(OpAdd, 32'h7fff_ffff, 32'h1, w);
    chk("add_out_valid", 32'(bus.out_valid), 32'd1);
    chk_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    op(OpSub, 32'd5, 32'd5, w);
    chk("b2b_waits", 32'(w), 32'd0);
    chk_out("sub_zero", 32'd0, 1'b1, 1'b0, 1'b0);
    op(OpAdd, 32'h8000_0000, 32'h8000_0000, w);
    chk_out("add_negovf", 32'd0, 1'b1, 1'b1, 1'b0);
    op(OpSub, 32'h8000_0000, 32'h1, w);
    chk_out("sub_ovf", 32'h7fff_ffff, 1'b0, 1'b1, 1'b0);

    // Signed compare across the overflow boundary.
    op(OpSlt, 32'h8000_0000, 32'h7fff_ffff, w);
    chk_out("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
    op(OpSlt, 32'h7fff_ffff, 32'h8000_0000, w);
    chk_out("slt_pos", 32'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure: result held, no accept, then accept on the release cycle.
    op(OpAnd, 32'hff00_ff00, 32'h0ff0_0ff0, w);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_result", bus.result, 32'h0f00_0f00);
    end
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    op(OpOr, 32'h1234_0000, 32'h0000_5678, w);
    chk("release_waits", 32'(w), 32'd0);
    chk_out("release_or", 32'h1234_5678, 1'b0, 1'b0, 1'b0);

    // Streaming OR, ADD, SUB.
    op(OpOr, 32'h0000_a0f0, 32'h0000_0f0a, w);
    chk("stream0_waits", 32'(w), 32'd0);
    chk_out("stream_or", 32'h0000_affa, 1'b0, 1'b0, 1'b0);
    op(OpAdd, 32'd100, 32'd23, w);
    chk("stream1_waits", 32'(w), 32'd0);
    chk_out("stream_add", 32'd123, 1'b0, 1'b0, 1'b0);
    op(OpSub, 32'd10, 32'd20, w);
    chk("stream2_waits", 32'(w), 32'd0);
    chk_out("stream_sub", 32'hffff_fff6, 1'b0, 1'b0, 1'b0);

    // Unsupported codes.
    op(3'b101, 32'h1234, 32'h5678, w);
    chk_out("ill_101", 32'd0, 1'b1, 1'b0, 1'b1);
    op(3'b100, 32'hffff_ffff, 32'h1, w);
    chk_out("ill_100", 32'd0, 1'b1, 1'b0, 1'b1);

`ifdef ALU_MUL_EN
    op(OpMul, 32'd3, 32'd5, w);
    chk("mul_busy_valid", 32'(bus.out_valid), 32'd0);
    chk("mul_busy_ready", 32'(bus.in_ready), 32'd0);
    wait_mul(32'd15);
    op(OpMul, 32'hffff_ffff, 32'hffff_ffff, w);
    wait_mul(32'd1);

    // Abort a multiply with reset.
    op(OpMul, 32'd7, 32'd9, w);
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk_out("abort", 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
`else
    op(OpMul, 32'd3, 32'd5, w);
    chk("mul_off_valid", 32'(bus.out_valid), 32'd1);
    chk_out("mul_off", 32'd0, 1'b1, 1'b0, 1'b1);
`endif

    op(OpAdd, 32'd1, 32'd1, w);
    chk_out("final_add", 32'd2, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    chk("drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
